// File: rtl/addertree_operand_sequencer.sv
// Serial-to-parallel operand loader for the 6-input adder tree. It also captures
// the tree sum after a programmable settle time and hands it out on a valid/ready port.
module addertree_operand_sequencer #(
    parameter int width = 23,
    parameter int LAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width:1]     in_data,
    input  logic               in_last,
    output logic [width:1]     A1,
    output logic [width:1]     A2,
    output logic [width:1]     A3,
    output logic [width:1]     A4,
    output logic [width:1]     A5,
    output logic [width:1]     A6,
    input  logic [width+3:1]   S,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [width+3:1]   res_data,
    output logic               busy
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [width:1]   a_reg [0:5];

    logic accept;
    logic group_end;
    logic settle_done;
    logic release_res;

    // Handshake qualifiers are built from state only, so ready/valid never
    // depend combinationally on the other side of the port.
    assign accept      = (state == LOAD) && in_valid;
    assign group_end   = accept && ((idx == 3'd5) || in_last);
    assign settle_done = (state == SETTLE) && (cnt == '0);
    assign release_res = (state == HOLD) && res_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (group_end)   state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = HOLD;
            HOLD:    if (release_res) state_nxt = LOAD;
            default:                  state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // idx is left at the terminating slot while settling/holding; busy still
    // reports correctly because the state is no longer LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (release_res) begin
            idx <= 3'd0;
        end else if (accept && !group_end) begin
            idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (group_end) begin
            cnt <= CNT_W'(LAT);
        end else if ((state == SETTLE) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Unwritten slots must read zero so short groups sum correctly; the
    // registers are therefore cleared on every result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 6; j++) a_reg[j] <= '0;
        end else if (release_res) begin
            for (int j = 0; j < 6; j++) a_reg[j] <= '0;
        end else if (accept) begin
            for (int j = 0; j < 6; j++) begin
                if (idx == 3'(j)) a_reg[j] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
        end else if (settle_done) begin
            res_data <= S;
        end
    end

    assign A1 = a_reg[0];
    assign A2 = a_reg[1];
    assign A3 = a_reg[2];
    assign A4 = a_reg[3];
    assign A5 = a_reg[4];
    assign A6 = a_reg[5];

    assign in_ready  = (state == LOAD);
    assign res_valid = (state == HOLD);
    assign busy      = (state != LOAD) || (idx != 3'd0);

endmodule

// File: tb/tb_addertree_operand_sequencer.sv
// Bench for addertree_operand_sequencer: one instance with LAT=0 and one with LAT=2,
// each checked every cycle against an event/timestamp model with an ideal-sum tree.
module tb_addertree_operand_sequencer;

    localparam int W = 23;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [W:1]    in_data   [2];
    logic          in_last   [2];
    logic [W:1]    a1 [2], a2 [2], a3 [2], a4 [2], a5 [2], a6 [2];
    logic [W+3:1]  s         [2];
    logic          res_valid [2];
    logic          res_ready [2];
    logic [W+3:1]  res_data  [2];
    logic          busy      [2];

    int total = 0;
    int bad   = 0;

    addertree_operand_sequencer #(.width(W), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]),
        .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .A4(a4[0]), .A5(a5[0]), .A6(a6[0]),
        .S(s[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .busy(busy[0])
    );

    addertree_operand_sequencer #(.width(W), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]),
        .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .A4(a4[1]), .A5(a5[1]), .A6(a6[1]),
        .S(s[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .busy(busy[1])
    );

    // Ideal combinational adder tree
    assign s[0] = 26'(a1[0]) + 26'(a2[0]) + 26'(a3[0]) + 26'(a4[0]) + 26'(a5[0]) + 26'(a6[0]);
    assign s[1] = 26'(a1[1]) + 26'(a2[1]) + 26'(a3[1]) + 26'(a4[1]) + 26'(a5[1]) + 26'(a6[1]);

    function automatic int lat_of(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    function automatic logic [W:1] dut_a(input int u, input int j);
        case (j)
            0: return a1[u];
            1: return a2[u];
            2: return a3[u];
            3: return a4[u];
            4: return a5[u];
            default: return a6[u];
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: operands collected per group; the result becomes visible at the
    // edge number due = (edge of closing operand) + 1 + LAT.
    int         ec;
    logic [W:1] m_a      [2][6];
    int         m_n      [2];
    bit         m_closed [2];
    bit         m_valid  [2];
    int         m_due    [2];
    logic [W+3:1] m_res  [2];
    logic [W+3:1] m_rd   [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ec = 0;
            for (int u = 0; u < 2; u++) begin
                for (int j = 0; j < 6; j++) m_a[u][j] = '0;
                m_n[u] = 0; m_closed[u] = 0; m_valid[u] = 0;
                m_due[u] = 0; m_res[u] = '0; m_rd[u] = '0;
            end
        end else begin
            ec = ec + 1;
            for (int u = 0; u < 2; u++) begin
                if (m_valid[u] && res_ready[u]) begin
                    for (int j = 0; j < 6; j++) m_a[u][j] = '0;
                    m_n[u] = 0; m_closed[u] = 0; m_valid[u] = 0;
                end else if (!m_closed[u] && in_valid[u]) begin
                    m_a[u][m_n[u]] = in_data[u];
                    m_n[u] = m_n[u] + 1;
                    if (m_n[u] == 6 || in_last[u]) begin
                        m_closed[u] = 1;
                        m_due[u] = ec + 1 + lat_of(u);
                        m_res[u] = '0;
                        for (int j = 0; j < 6; j++) m_res[u] = m_res[u] + 26'(m_a[u][j]);
                    end
                end
                if (m_closed[u] && !m_valid[u] && ec == m_due[u]) begin
                    m_valid[u] = 1;
                    m_rd[u] = m_res[u];
                end
            end
        end
    end

    // Per-cycle compare away from the active edge
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d in_ready", u), 64'(in_ready[u]), 64'(!m_closed[u]));
            chk($sformatf("u%0d res_valid", u), 64'(res_valid[u]), 64'(m_valid[u]));
            chk($sformatf("u%0d busy", u), 64'(busy[u]), 64'(m_closed[u] || m_n[u] != 0));
            chk($sformatf("u%0d res_data", u), 64'(res_data[u]), 64'(m_rd[u]));
            for (int j = 0; j < 6; j++)
                chk($sformatf("u%0d A%0d", u, j + 1), 64'(dut_a(u, j)), 64'(m_a[u][j]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [W:1] d, input logic last, output int k);
        logic acc;
        k = -1;
        in_valid[u] = 1'b1; in_data[u] = d; in_last[u] = last;
        for (int t = 0; t < 50; t++) begin
            acc = in_ready[u];
            step();
            if (acc) begin
                k = ec;
                break;
            end
        end
        if (k < 0) chk($sformatf("u%0d accept timeout", u), 64'(0), 64'(1));
        in_valid[u] = 1'b0; in_last[u] = 1'b0;
    endtask

    task automatic wait_result(input int u, input logic [W+3:1] exp, output int v);
        v = -1;
        for (int t = 0; t < 60; t++) begin
            if (res_valid[u]) begin
                v = ec;
                break;
            end
            step();
        end
        if (v < 0) chk($sformatf("u%0d result timeout", u), 64'(0), 64'(1));
        chk($sformatf("u%0d result value", u), 64'(res_data[u]), 64'(exp));
    endtask

    task automatic hold_release(input int u, input int n);
        logic [W+3:1] held;
        held = res_data[u];
        for (int t = 0; t < n; t++) begin
            chk($sformatf("u%0d hold in_ready", u), 64'(in_ready[u]), 64'(0));
            chk($sformatf("u%0d hold res_data", u), 64'(res_data[u]), 64'(held));
            step();
        end
        res_ready[u] = 1'b1;
        step();
        res_ready[u] = 1'b0;
        chk($sformatf("u%0d post-hs res_valid", u), 64'(res_valid[u]), 64'(0));
        chk($sformatf("u%0d post-hs in_ready", u), 64'(in_ready[u]), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, v, len;
        logic [W+3:1] sum;
        logic [W:1] d;
        logic last;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 0; in_data[u] = '0; in_last[u] = 0; res_ready[u] = 0;
        end
        #1 rst = 1'b1;
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            chk("reset in_ready", 64'(in_ready[u]), 64'(1));
            chk("reset res_valid", 64'(res_valid[u]), 64'(0));
            chk("reset busy", 64'(busy[u]), 64'(0));
            chk("reset res_data", 64'(res_data[u]), 64'(0));
        end
        rst = 1'b0;
        step();
        chk("first cycle in_ready", 64'(in_ready[0]), 64'(1));

        // Full group, LAT=0
        for (int i = 1; i <= 6; i++) send(0, W'(i), 1'b0, k);
        wait_result(0, 26'd21, v);
        chk("lat0 capture delay", 64'(v - k), 64'(1));
        for (int j = 0; j < 6; j++) chk("full A value", 64'(dut_a(0, j)), 64'(j + 1));
        hold_release(0, 2);

        // Max operands
        for (int i = 0; i < 6; i++) send(0, 23'h7FFFFF, 1'b0, k);
        wait_result(0, 26'd50331642, v);
        hold_release(0, 1);
        for (int j = 0; j < 6; j++) chk("cleared A", 64'(dut_a(0, j)), 64'(0));

        // Short group, then next group restarts at A1
        send(0, 23'd100, 1'b0, k);
        send(0, 23'd200, 1'b1, k);
        wait_result(0, 26'd300, v);
        chk("short A1", 64'(a1[0]), 64'(100));
        chk("short A2", 64'(a2[0]), 64'(200));
        for (int j = 2; j < 6; j++) chk("short zero slot", 64'(dut_a(0, j)), 64'(0));
        hold_release(0, 0);
        send(0, 23'd5, 1'b1, k);
        wait_result(0, 26'd5, v);
        chk("restart A1", 64'(a1[0]), 64'(5));
        chk("restart A2", 64'(a2[0]), 64'(0));
        hold_release(0, 0);

        // Backpressure, LAT=2; in_valid kept high through SETTLE/HOLD
        send(1, 23'd11, 1'b0, k);
        step(); step();
        send(1, 23'd22, 1'b0, k);
        step();
        send(1, 23'd33, 1'b1, k);
        in_valid[1] = 1'b1; in_data[1] = 23'd77; in_last[1] = 1'b1;
        wait_result(1, 26'd66, v);
        chk("lat2 capture delay", 64'(v - k), 64'(3));
        hold_release(1, 5);
        step();
        in_valid[1] = 1'b0; in_last[1] = 1'b0;
        chk("held operand A1", 64'(a1[1]), 64'(77));
        chk("held operand busy", 64'(busy[1]), 64'(1));
        wait_result(1, 26'd77, v);
        hold_release(1, 0);

        // Reset mid-group
        send(0, 23'd7, 1'b0, k);
        send(0, 23'd8, 1'b0, k);
        send(0, 23'd9, 1'b0, k);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 64'(in_ready[0]), 64'(1));
        chk("midrst busy", 64'(busy[0]), 64'(0));
        chk("midrst res_valid", 64'(res_valid[0]), 64'(0));
        for (int j = 0; j < 6; j++) chk("midrst A", 64'(dut_a(0, j)), 64'(0));
        step();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) send(0, W'(10 * i), 1'b0, k);
        wait_result(0, 26'd210, v);
        hold_release(0, 1);

        // Random groups with stalls on both instances
        for (int u = 0; u < 2; u++) begin
            for (int g = 0; g < 50; g++) begin
                len = $urandom_range(1, 6);
                sum = '0;
                for (int j = 0; j < len; j++) begin
                    repeat ($urandom_range(0, 2)) step();
                    d = W'($urandom);
                    last = (j == len - 1) && (len < 6 || $urandom_range(0, 1) == 1);
                    sum = sum + 26'(d);
                    send(u, d, last, k);
                end
                wait_result(u, sum, v);
                chk("random latency", 64'(v - k), 64'(lat_of(u) + 1));
                hold_release(u, $urandom_range(0, 3));
            end
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addertree_operand_sequencer.md
# addertree_operand_sequencer

Sequential front end for the 6-operand, 23-bit adder tree. It accepts operands one per handshake on a valid/ready stream and holds them in registers that drive the tree's parallel A1..A6 inputs. After a programmable settle time it captures the tree's sum S and presents it as a registered result with valid/ready handshake. It is the driving and consuming end of the adder-tree port set, used wherever operands arrive serially instead of as a parallel word.

## Interface
- width, 23: operand width; tree sum width is width+3.
- LAT, 0: extra settle cycles between the last operand register update and sum capture (0 = combinational tree).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  sequencer accepts an operand this cycle.
- in_data  in  [width:1]  operand value.
- in_last  in  1  operand is the final one of this group; remaining slots stay zero.
- A1..A6  out  [width:1] each  registered operands to the adder tree.
- S  in  [width+3:1]  adder-tree sum.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  [width+3:1]  captured sum.
- busy  out  1  high in any state other than LOAD with zero operands accepted.

## Operation
- States: LOAD, SETTLE, HOLD. Reset state is LOAD.
- Slot index idx, 0..5. It selects the A register written next.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_data to A[idx+1] and increment idx.
  - If idx==5 or in_last, go to SETTLE instead and load the settle counter with LAT.
  - in_last with idx==5 is a single terminating event and is not an error.
- SETTLE:
  - in_ready=0.
  - The counter decrements each cycle.
  - When the counter is 0, capture S into res_data and go to HOLD.
- HOLD:
  - in_ready=0 and res_valid=1.
  - res_data and A1..A6 are stable.
  - On res_ready, clear A1..A6 and idx to 0, drop res_valid and go to LOAD.
- Slots not written in a group read 0, so a short group sums correctly.
- Arithmetic: the sequencer does not add. S is trusted.
  - 6·(2^width−1) fits in width+3 bits, so there is no overflow case.
- No overlap: the next group's first operand is accepted no earlier than the cycle after the result handshake.
- Reset, asynchronous, from any state:
  - A1..A6=0, idx=0, res_data=0, res_valid=0.
  - State=LOAD and the counter is cleared.
  - A partially loaded group is discarded.
  - After rst falls, in_ready=1 in the first cycle.

## Timing
- Reset values:
  - in_ready=1 (combinational from state LOAD; high during reset too).
  - res_valid=0, res_data=0, A1..A6=0, busy=0.
- in_ready and res_valid are decoded from state only, with no combinational path from in_valid or res_ready.
- Final operand accepted at edge k:
  - A registers are updated at k.
  - State is SETTLE for LAT+1 cycles.
  - S is captured at edge k+1+LAT.
  - res_valid is high from k+1+LAT.
- LAT=0: result is valid the cycle after the final operand is accepted, so there is one SETTLE cycle.
- Result handshake at edge h: res_valid=0 and in_ready=1 from h. The earliest next operand acceptance is at edge h+1.
- Throughput for a full group: 6 + (LAT+1) + 1 cycles minimum.
- in_data and in_last are sampled only when in_valid&&in_ready.
- in_valid held high during SETTLE or HOLD is ignored, and no operand is dropped or duplicated.

## Test plan
- Full group, LAT=0:
  - Stimulus: operands 1,2,3,4,5,6 back-to-back.
  - Required: res_data=21 one cycle after the 6th acceptance; A1..A6=1..6 while res_valid.
- Max values:
  - Stimulus: six operands 0x7FFFFF.
  - Required: res_data=0x2FFFFFA (50331642); then, after res_ready, A1..A6 read 0.
- Short group:
  - Stimulus: 100, then 200 with in_last.
  - Required: A3..A6=0 and res_data=300; the next group starts at A1.
- Backpressure, LAT=2:
  - Stimulus: in_valid gaps during LOAD; res_ready held low 5 cycles in HOLD.
  - Required: capture exactly 3 cycles after the last acceptance; res_data stable and in_ready=0 throughout HOLD; in_valid high during HOLD accepted only after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst after 3 operands (7,8,9) accepted.
  - Required: outputs return immediately to reset values. A new group 10,20,30,40,50,60 gives 210, with no residue of 7,8,9.
- Random:
  - Stimulus: 50 random groups (random lengths 1..6, random valid/ready stalls), tree modeled as an ideal sum.
  - Required: every res_data equals the sum of its group's operands.
